// File: rtl/i2s_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_sample_packer
//  Purpose  : Pops sign-extended samples from the I2S sample FIFO and packs
//             1, 2 or 4 of them into a 32-bit word on a valid/ready stream.
//             Also tracks the peak absolute sample value and counts emitted
//             words.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             en                  - allow FIFO pops
//             pack_mode[1:0]      - 00/11: 1x32, 01: 2x16, 10: 4x8 lanes
//             flush               - emit a partial word (zero padded)
//             fifo_empty,
//             fifo_rdata[31:0]    - FIFO head
//             fifo_rd             - combinational pop strobe
//             m_valid, m_ready,
//             m_data[31:0]        - output stream, lane 0 in the LSBs
//             peak_clr, peak      - peak |sample| tracker and its clear
//             word_count[15:0]    - completed handshakes (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pack_mode,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rdata,
    output logic        fifo_rd,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    input  logic        peak_clr,
    output logic [31:0] peak,
    output logic [15:0] word_count
);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_OUT  = 1'b1;

    localparam logic [1:0] c_MODE_32 = 2'b00;
    localparam logic [1:0] c_MODE_16 = 2'b01;
    localparam logic [1:0] c_MODE_8  = 2'b10;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_lane_idx;
    logic [1:0]  w_lane_idx_nxt;
    logic [1:0]  r_mode_q;
    logic [1:0]  w_mode_q_nxt;
    logic [31:0] r_acc;
    logic [31:0] w_acc_nxt;
    logic [31:0] r_peak;
    logic [31:0] w_peak_nxt;
    logic [15:0] r_word_count;

    logic [1:0]  w_mode_raw;
    logic [1:0]  w_mode;
    logic        w_pop;
    logic        w_last;
    logic        w_handshake;
    logic [7:0]  w_abs8;
    logic [15:0] w_abs16;
    logic [31:0] w_abs32;
    logic [31:0] w_abs;

    // The first pop of a word uses the live pack_mode (it is also the cycle
    // mode_q captures it); later lanes stay on the captured mode.
    assign w_mode_raw = (r_lane_idx == 2'd0) ? pack_mode : r_mode_q;
    assign w_mode     = (w_mode_raw == 2'b11) ? c_MODE_32 : w_mode_raw;

    assign w_pop       = (r_state == S_FILL) & en & ~fifo_empty & ~rst;
    assign w_handshake = (r_state == S_OUT) & m_ready;

    always_comb begin
        w_last = 1'b0;
        case (w_mode)
            c_MODE_16: w_last = (r_lane_idx == 2'd1);
            c_MODE_8:  w_last = (r_lane_idx == 2'd3);
            default:   w_last = 1'b1;
        endcase
    end

    // Absolute value at each lane width; the most negative code has no
    // positive counterpart and saturates to the largest positive value.
    assign w_abs8  = fifo_rdata[7]  ? ((fifo_rdata[7:0]  == 8'h80)         ? 8'h7F         : (~fifo_rdata[7:0]  + 8'd1))  : fifo_rdata[7:0];
    assign w_abs16 = fifo_rdata[15] ? ((fifo_rdata[15:0] == 16'h8000)      ? 16'h7FFF      : (~fifo_rdata[15:0] + 16'd1)) : fifo_rdata[15:0];
    assign w_abs32 = fifo_rdata[31] ? ((fifo_rdata       == 32'h8000_0000) ? 32'h7FFF_FFFF : (~fifo_rdata       + 32'd1)) : fifo_rdata;

    always_comb begin
        w_abs = w_abs32;
        case (w_mode)
            c_MODE_16: w_abs = {16'd0, w_abs16};
            c_MODE_8:  w_abs = {24'd0, w_abs8};
            default:   w_abs = w_abs32;
        endcase
    end

    // Next-state, lane and accumulator logic
    always_comb begin
        w_state_nxt    = r_state;
        w_lane_idx_nxt = r_lane_idx;
        w_mode_q_nxt   = r_mode_q;
        w_acc_nxt      = r_acc;
        case (r_state)
            S_FILL: begin
                if (w_pop) begin
                    if (r_lane_idx == 2'd0) begin
                        w_mode_q_nxt = w_mode;
                    end
                    case (w_mode)
                        c_MODE_16: begin
                            if (r_lane_idx[0]) w_acc_nxt[31:16] = fifo_rdata[15:0];
                            else               w_acc_nxt[15:0]  = fifo_rdata[15:0];
                        end
                        c_MODE_8: begin
                            case (r_lane_idx)
                                2'd0:    w_acc_nxt[7:0]   = fifo_rdata[7:0];
                                2'd1:    w_acc_nxt[15:8]  = fifo_rdata[7:0];
                                2'd2:    w_acc_nxt[23:16] = fifo_rdata[7:0];
                                default: w_acc_nxt[31:24] = fifo_rdata[7:0];
                            endcase
                        end
                        default: w_acc_nxt = fifo_rdata;
                    endcase
                    if (w_last) begin
                        w_state_nxt    = S_OUT;
                        w_lane_idx_nxt = 2'd0;
                    end else begin
                        w_lane_idx_nxt = r_lane_idx + 2'd1;
                    end
                end else if (flush && (r_lane_idx != 2'd0)) begin
                    // Unfilled lanes are already zero: acc is cleared on
                    // every handshake and on reset.
                    w_state_nxt    = S_OUT;
                    w_lane_idx_nxt = 2'd0;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    w_state_nxt = S_FILL;
                    w_acc_nxt   = 32'd0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // A pop in the clear cycle restarts tracking from that sample.
    always_comb begin
        w_peak_nxt = r_peak;
        if (w_pop) begin
            if (peak_clr || (w_abs > r_peak)) begin
                w_peak_nxt = w_abs;
            end
        end else if (peak_clr) begin
            w_peak_nxt = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_lane_idx   <= 2'd0;
            r_mode_q     <= c_MODE_32;
            r_acc        <= 32'd0;
            r_peak       <= 32'd0;
            r_word_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_idx <= w_lane_idx_nxt;
            r_mode_q   <= w_mode_q_nxt;
            r_acc      <= w_acc_nxt;
            r_peak     <= w_peak_nxt;
            if (w_handshake) begin
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

    assign fifo_rd    = w_pop;
    assign m_valid    = (r_state == S_OUT);
    assign m_data     = r_acc;
    assign peak       = r_peak;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_sample_packer
//  Purpose  : Self-checking bench for i2s_sample_packer: a table of directed
//             cycle vectors followed by randomized traffic compared against a
//             sample-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pack_mode;
    logic        flush;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rd;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        peak_clr;
    logic [31:0] peak;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    i2s_sample_packer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pack_mode  (pack_mode),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .peak_clr   (peak_clr),
        .peak       (peak),
        .word_count (word_count)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  pm;
        logic        fl;
        logic        em;
        logic [31:0] rdata;
        logic        rdy;
        logic        pclr;
        logic        x_rd;
        logic        x_vld;
        logic        chk_data;
        logic [31:0] x_data;
        logic [31:0] x_peak;
        logic [15:0] x_wc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic e, input logic [1:0] pm, input logic fl,
                       input logic em, input logic [31:0] rd, input logic rdy, input logic pc,
                       input logic x_rd, input logic x_vld, input logic cd,
                       input logic [31:0] x_data, input logic [31:0] x_peak, input logic [15:0] x_wc);
        vec_t v;
        v.rst = r; v.en = e; v.pm = pm; v.fl = fl; v.em = em; v.rdata = rd; v.rdy = rdy;
        v.pclr = pc; v.x_rd = x_rd; v.x_vld = x_vld; v.chk_data = cd; v.x_data = x_data;
        v.x_peak = x_peak; v.x_wc = x_wc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: list of samples of the open word ----
    bit          mv;
    logic [31:0] mw;
    logic [31:0] ms[$];
    int          mL;
    logic [31:0] mpeak;
    logic [15:0] mwc;

    function automatic int lane_bits(input logic [1:0] m);
        if (m == 2'b01) return 16;
        if (m == 2'b10) return 8;
        return 32;
    endfunction

    function automatic logic [31:0] spec_abs(input logic [31:0] s, input int L);
        longint v;
        longint lim;
        v   = longint'(s);
        lim = longint'(1) << (L - 1);
        if (v >= lim) v = v - 2 * lim;
        if (v < 0) v = -v;
        if (v > lim - 1) v = lim - 1;
        return v[31:0];
    endfunction

    task automatic model_reset();
        mv = 0; mw = '0; ms.delete(); mL = 32; mpeak = '0; mwc = '0;
    endtask

    task automatic model_emit();
        mw = '0;
        foreach (ms[i]) mw = mw | (ms[i] << (mL * i));
        mv = 1;
        ms.delete();
    endtask

    task automatic model_step();
        logic [31:0] s;
        logic [31:0] a;
        logic [31:0] mask;
        bit          popped;
        popped = 0;
        a      = '0;
        if (rst) begin
            model_reset();
        end else begin
            if (mv) begin
                if (m_ready) begin
                    mv  = 0;
                    mwc = mwc + 16'd1;
                end
            end else if (en && !fifo_empty) begin
                if (ms.size() == 0) mL = lane_bits(pack_mode);
                mask = (mL == 32) ? 32'hFFFF_FFFF : ((32'h1 << mL) - 32'h1);
                s = fifo_rdata & mask;
                a = spec_abs(s, mL);
                popped = 1;
                ms.push_back(s);
                if (ms.size() == 32 / mL) model_emit();
            end else if (flush && ms.size() > 0) begin
                model_emit();
            end
            if (popped) begin
                if (peak_clr || a > mpeak) mpeak = a;
            end else if (peak_clr) begin
                mpeak = '0;
            end
        end
    endtask

    function automatic logic [31:0] pick_data();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) return 32'h0000_0080;
        if (k == 1) return 32'hFFFF_8000;
        if (k == 2) return 32'h8000_0000;
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; pack_mode = 2'b00; flush = 1'b0; fifo_empty = 1'b0;
        fifo_rdata = 32'h55; m_ready = 1'b0; peak_clr = 1'b0;

        // Reset
        add(1,1,2'b00,0,0,32'h55,0,0,        0,0,1,32'h0,32'h0,16'd0);
        add(1,1,2'b00,0,0,32'h55,0,0,        0,0,1,32'h0,32'h0,16'd0);
        // Two 16-bit lanes
        add(0,1,2'b01,0,0,32'h0000_1234,1,0, 1,0,0,32'h0,32'h0,16'd0);
        add(0,1,2'b01,0,0,32'hFFFF_ABCD,1,0, 1,0,0,32'h0,32'h1234,16'd0);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,1,1,32'hABCD_1234,32'h5433,16'd0);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,0,0,32'h0,32'h5433,16'd1);
        // Four 8-bit lanes, flushed after three
        add(0,1,2'b10,0,0,32'h11,1,0,        1,0,0,32'h0,32'h5433,16'd1);
        add(0,1,2'b10,0,0,32'h22,1,0,        1,0,0,32'h0,32'h5433,16'd1);
        add(0,1,2'b10,0,0,32'h33,1,0,        1,0,0,32'h0,32'h5433,16'd1);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,0,0,32'h0,32'h5433,16'd1);
        add(0,1,2'b10,1,1,32'h0,0,0,         0,0,0,32'h0,32'h5433,16'd1);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,1,1,32'h0033_2211,32'h5433,16'd1);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,0,0,32'h0,32'h5433,16'd2);
        // Backpressure in 32-bit mode
        add(0,1,2'b00,0,0,32'hDEAD_BEEF,0,0, 1,0,0,32'h0,32'h5433,16'd2);
        for (int i = 0; i < 5; i++)
            add(0,1,2'b00,0,0,32'h1234_5678,0,0, 0,1,1,32'hDEAD_BEEF,32'h2152_4111,16'd2);
        add(0,1,2'b00,0,1,32'h0,1,0,         0,1,1,32'hDEAD_BEEF,32'h2152_4111,16'd2);
        add(0,1,2'b00,0,1,32'h0,1,1,         0,0,0,32'h0,32'h2152_4111,16'd3);
        // Peak saturation and clear-with-pop
        add(0,1,2'b01,0,0,32'h0000_8000,1,0, 1,0,0,32'h0,32'h0,16'd3);
        add(0,1,2'b01,0,0,32'h0000_0100,1,0, 1,0,0,32'h0,32'h7FFF,16'd3);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,1,1,32'h0100_8000,32'h7FFF,16'd3);
        add(0,1,2'b01,0,0,32'h0000_FFFE,1,1, 1,0,0,32'h0,32'h7FFF,16'd4);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,0,0,32'h0,32'h2,16'd4);
        add(0,1,2'b01,1,1,32'h0,1,0,         0,0,0,32'h0,32'h2,16'd4);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,1,1,32'h0000_FFFE,32'h2,16'd4);
        // Stall mid-word, mode change only takes effect on the next word
        add(0,1,2'b01,0,0,32'hAAAA_5555,1,0, 1,0,0,32'h0,32'h2,16'd5);
        for (int i = 0; i < 3; i++)
            add(0,1,2'b01,0,1,32'h0,1,0,     0,0,0,32'h0,32'h5555,16'd5);
        add(0,1,2'b10,0,0,32'h0000_7F01,1,0, 1,0,0,32'h0,32'h5555,16'd5);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,1,1,32'h7F01_5555,32'h7F01,16'd5);
        add(0,1,2'b10,0,0,32'h81,1,0,        1,0,0,32'h0,32'h7F01,16'd6);
        add(0,1,2'b10,0,0,32'h02,1,0,        1,0,0,32'h0,32'h7F01,16'd6);
        add(0,1,2'b10,0,0,32'h03,1,0,        1,0,0,32'h0,32'h7F01,16'd6);
        add(0,1,2'b10,0,0,32'h04,1,0,        1,0,0,32'h0,32'h7F01,16'd6);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,1,1,32'h0403_0281,32'h7F01,16'd6);
        add(0,1,2'b10,0,1,32'h0,1,0,         0,0,0,32'h0,32'h7F01,16'd7);
        // Reset in the middle of a word
        add(0,1,2'b01,0,0,32'h1111,1,0,      1,0,0,32'h0,32'h7F01,16'd7);
        add(1,1,2'b01,0,0,32'h2222,1,0,      0,0,0,32'h0,32'h7F01,16'd7);
        add(0,1,2'b01,0,1,32'h0,1,0,         0,0,1,32'h0,32'h0,16'd0);
        // Mode 11 behaves as 32-bit, en=0 blocks pops, flush with no data ignored
        add(0,1,2'b11,0,0,32'h0000_0080,1,0, 1,0,0,32'h0,32'h0,16'd0);
        add(0,1,2'b11,0,1,32'h0,1,0,         0,1,1,32'h0000_0080,32'h80,16'd0);
        add(0,1,2'b11,0,1,32'h0,1,0,         0,0,0,32'h0,32'h80,16'd1);
        add(0,0,2'b00,0,0,32'h9,1,0,         0,0,0,32'h0,32'h80,16'd1);
        add(0,1,2'b00,1,1,32'h0,1,0,         0,0,0,32'h0,32'h80,16'd1);
        add(0,1,2'b00,0,1,32'h0,1,0,         0,0,0,32'h0,32'h80,16'd1);

        repeat (3) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; pack_mode = vecs[i].pm; flush = vecs[i].fl;
            fifo_empty = vecs[i].em; fifo_rdata = vecs[i].rdata; m_ready = vecs[i].rdy;
            peak_clr = vecs[i].pclr;
            @(negedge clk);
            check($sformatf("vec%0d fifo_rd", i), {31'd0, fifo_rd}, {31'd0, vecs[i].x_rd});
            check($sformatf("vec%0d m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].x_vld});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d m_data", i), m_data, vecs[i].x_data);
            check($sformatf("vec%0d peak", i), peak, vecs[i].x_peak);
            check($sformatf("vec%0d word_count", i), {16'd0, word_count}, {16'd0, vecs[i].x_wc});
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model
        rst = 1'b1; flush = 1'b0; peak_clr = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            en         = ($urandom_range(0, 9) != 0);
            pack_mode  = 2'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 9) == 0);
            fifo_empty = ($urandom_range(0, 3) == 0);
            fifo_rdata = pick_data();
            m_ready    = ($urandom_range(0, 2) != 0);
            peak_clr   = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            check("rnd fifo_rd", {31'd0, fifo_rd}, {31'd0, (!rst && !mv && en && !fifo_empty)});
            check("rnd m_valid", {31'd0, m_valid}, {31'd0, mv});
            if (mv) check("rnd m_data", m_data, mw);
            check("rnd peak", peak, mpeak);
            check("rnd word_count", {16'd0, word_count}, {16'd0, mwc});
            model_step();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_sample_packer.md
# i2s_sample_packer

Downstream consumer of the I2S receiver's sample FIFO. Pops sign-extended samples from the FIFO, packs 1, 2 or 4 samples into a 32-bit word and presents it on a valid/ready stream toward the bus/DMA side. It also tracks the peak absolute sample value and counts emitted words. Sits between the I2S FIFO read port and the system data mover.

## Interface
- No parameters. The data width is fixed at 32 bits.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  enables FIFO pops. Deasserting it does not drop held data.
- `pack_mode`  in  2  `00` = one 32-bit sample per word; `01` = two 16-bit lanes; `10` = four 8-bit lanes; `11` behaves as `00`.
- `flush`  in  1  level-sensitive. Emits a partially filled word, zero-padded.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  32  FIFO head word. Valid whenever `fifo_empty`=0.
- `fifo_rd`  out  1  combinational pop strobe. The head is consumed at the clock edge.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  32  packed word. Lane 0 = first sample, in bits [L-1:0].
- `peak_clr`  in  1  synchronous clear of `peak`.
- `peak`  out  32  maximum absolute sample value since reset or clear.
- `word_count`  out  16  number of completed output handshakes (wraps).

## Operation
- State machine has two states, FILL and OUT. Reset state is FILL.
- Internal registers: `lane_idx` (2 bits), `mode_q`, and data accumulator `acc`.
- Lane width L and lane count N:
  - mode `00`: L=32, N=1.
  - mode `01`: L=16, N=2.
  - mode `10`: L=8, N=4.
- `mode_q` loads `pack_mode` only in FILL with `lane_idx`=0, on the cycle of a pop. It is held constant for the rest of the word.
- FILL:
  - `fifo_rd` = `en` & ~`fifo_empty` & ~`rst`.
  - On a pop, `fifo_rdata[L-1:0]` is written to lane `lane_idx` of `acc` and `lane_idx` increments.
  - The pop that fills lane N-1 moves to OUT and resets `lane_idx` to 0.
  - If `flush`=1, no pop occurs that cycle, and `lane_idx`>0: move to OUT. Unfilled lanes are 0.
  - If `flush`=1 and `lane_idx`=0, flush is ignored.
  - A pop takes priority over flush in the same cycle.
- OUT:
  - `m_valid`=1 and `m_data`=`acc`. `fifo_rd`=0.
  - On `m_valid`&`m_ready`: `word_count`++, clear `acc`, return to FILL.
  - `m_data` is held stable until accepted, independent of `en`.
- Peak tracking:
  - Each popped sample is interpreted as an L-bit two's complement value: A = |sample|.
  - The most-negative value saturates to 2^(L-1)-1.
  - If A > `peak`, `peak` <= A.
  - `peak_clr` sets `peak` to 0. If `peak_clr` and a pop happen in the same cycle, `peak` <= A.
- Reset values: state FILL, `lane_idx` 0, `acc`/`m_data` 0, `m_valid` 0, `fifo_rd` 0, `peak` 0, `word_count` 0, `mode_q` `00`.
- Asserting `rst` mid-word discards the partial word. No pop occurs in the reset cycle.

## Timing
- Mode `00`: pop in cycle T, `m_valid` high at T+1.
- Mode `01`: pops in T and T+1, `m_valid` high at T+2.
- Mode `10`: pops in T..T+3, `m_valid` high at T+4.
- After a handshake in cycle H, `m_valid`=0 at H+1 and `fifo_rd` may be 1 in H+1.
- Peak throughput is one word per N+1 cycles.
- `peak` and `word_count` update at the edge ending the pop or handshake cycle.
- An empty FIFO mid-word stalls in FILL with `lane_idx` held; the next available sample fills the next lane.
- `word_count` wraps from 0xFFFF to 0x0000.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `fifo_empty`=0 -> `fifo_rd`=0 throughout, all outputs at reset values.
- **Mode `01`:** FIFO words 0x00001234 then 0xFFFFABCD, `m_ready`=1 -> one word `m_data`=0xABCD1234; `fifo_rd` high for 2 cycles; `m_valid` for 1 cycle; `word_count`=1.
- **Mode `10` with flush:** pop 0x11, 0x22, 0x33, then FIFO goes empty; pulse `flush` -> `m_data`=0x00332211.
- **Backpressure:** mode `00`, word 0xDEADBEEF, `m_ready`=0 for 5 cycles -> `m_valid` and `m_data` stable for 5 cycles, no pops; accepted on cycle 6.
- **Peak:**
  - Mode `01` samples 0x8000, 0x0100 -> `peak`=0x7FFF.
  - Then `peak_clr` together with a pop of 0xFFFE -> `peak`=0x0002.
- **Stall and mode change:**
  - Mode `01`, one pop, FIFO empty 3 cycles, then `pack_mode` switched to `10` and another pop -> word packed as 16-bit lanes.
  - Next word uses 8-bit lanes.
